// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (pipeline P, DMA D).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed P-over-D priority.
module dmem_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_ack,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t     state, state_next;
  logic       owner;
  logic [3:0] cnt;
  logic       grant_valid;
  logic       grant_d;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  always_comb begin
    grant_valid = p_req | d_req;
    grant_d     = (p_req & d_req) ? rr_ptr : d_req;
  end
`else
  always_comb begin
    grant_valid = p_req | d_req;
    grant_d     = ~p_req & d_req;
  end
`endif

  assign p_stall = p_req & ~p_ack;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = m_we ? DONE : WAIT;
      WAIT:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Every read passes through WAIT: data is valid LAT cycles after ACCESS, so even LAT=1 needs one capture cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      cnt     <= 4'd0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      p_rdata <= '0;
      d_rdata <= '0;
      p_ack   <= 1'b0;
      d_ack   <= 1'b0;
      busy    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr  <= 1'b0;
`endif
    end else begin
      m_en  <= 1'b0;
      p_ack <= 1'b0;
      d_ack <= 1'b0;
      busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (grant_valid) begin
            m_en    <= 1'b1;
            owner   <= grant_d;
            m_we    <= grant_d ? d_we    : p_we;
            m_addr  <= grant_d ? d_addr  : p_addr;
            m_wdata <= grant_d ? d_wdata : p_wdata;
`ifdef DMEM_ARB_RR_EN
            rr_ptr  <= ~grant_d;
`endif
          end
        end
        ACCESS: begin
          if (m_we) begin
            p_ack <= ~owner;
            d_ack <= owner;
          end else begin
            cnt <= 4'(LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (owner) d_rdata <= m_rdata;
            else       p_rdata <= m_rdata;
            p_ack <= ~owner;
            d_ack <= owner;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance 0 uses LAT=1, instance 1 uses LAT=3, each with its own memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p_req   [2];
  logic        p_we    [2];
  logic [15:0] p_addr  [2];
  logic [15:0] p_wdata [2];
  logic [15:0] p_rdata [2];
  logic        p_ack   [2];
  logic        p_stall [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [15:0] d_addr  [2];
  logic [15:0] d_wdata [2];
  logic [15:0] d_rdata [2];
  logic        d_ack   [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [15:0] m_addr  [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rdata [2];
  logic        busy    [2];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reads appear exactly L cycles after the m_en cycle, garbage otherwise.
  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int L = (k == 0) ? 1 : 3;
    logic [15:0] mem  [256];
    logic [15:0] pipe [1:15];

    dmem_arbiter #(.AW(16), .DW(16), .LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .p_req(p_req[k]), .p_we(p_we[k]), .p_addr(p_addr[k]), .p_wdata(p_wdata[k]),
      .p_rdata(p_rdata[k]), .p_ack(p_ack[k]), .p_stall(p_stall[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_rdata(d_rdata[k]), .d_ack(d_ack[k]),
      .m_en(m_en[k]), .m_we(m_we[k]), .m_addr(m_addr[k]), .m_wdata(m_wdata[k]),
      .m_rdata(m_rdata[k]), .busy(busy[k])
    );

    always @(posedge clk) begin
      pipe[1] <= (m_en[k] && !m_we[k]) ? mem[m_addr[k][7:0]] : 16'hDEAD;
      for (int i = 2; i <= 15; i++) pipe[i] <= pipe[i-1];
      if (m_en[k] && m_we[k]) mem[m_addr[k][7:0]] <= m_wdata[k];
    end

    assign m_rdata[k] = pipe[L];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction on port P (is_d=0) or D (is_d=1), starting with the arbiter idle.
  task automatic applyStimulus(input int k, input bit is_d, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata, input int exp_lat,
                               input logic [15:0] exp_rdata, input string tag);
    int n, busy_n, stall_n;
    bit got, other;
    @(negedge clk);
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      p_req[k] = 1'b1; p_we[k] = we; p_addr[k] = addr; p_wdata[k] = wdata;
    end
    n = 0; busy_n = 0; stall_n = 0; got = 1'b0; other = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (busy[k]) busy_n++;
      if (is_d ? p_ack[k] : d_ack[k]) other = 1'b1;
      got = is_d ? d_ack[k] : p_ack[k];
      if (!got && p_stall[k]) stall_n++;
    end
    checkOutput({tag, "_latency"}, got ? 32'(n) : 32'd99, 32'(exp_lat));
    if (!we) checkOutput({tag, "_rdata"}, 32'(is_d ? d_rdata[k] : p_rdata[k]), 32'(exp_rdata));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    checkOutput({tag, "_stall_cycles"}, 32'(stall_n), is_d ? 32'd0 : 32'(exp_lat - 1));
    checkOutput({tag, "_other_ack"}, 32'(other), 32'd0);
    if (is_d) d_req[k] = 1'b0;
    else      p_req[k] = 1'b0;
  endtask

  initial begin
    int pn, dn, idx, d_seen;
    int order [4];
`ifdef DMEM_ARB_RR_EN
    int exp_order [4] = '{0, 1, 0, 1};
`else
    int exp_order [4] = '{0, 0, 0, 0};
`endif

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p_req[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    checkOutput("rst_p_ack", 32'(p_ack[0]), 32'd0);
    checkOutput("rst_m_en", 32'(m_en[0]), 32'd0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_m_addr", 32'(m_addr[1]), 32'd0);
    checkOutput("rst_p_rdata", 32'(p_rdata[1]), 32'd0);
    rst = 1'b0;

    $display("[TB] t1: single P write, LAT=1");
    @(negedge clk);
    p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 16'h0010; p_wdata[0] = 16'hBEEF;
    #1;
    checkOutput("t1_stall_on_req", 32'(p_stall[0]), 32'd1);
    @(negedge clk);
    checkOutput("t1_m_en", 32'(m_en[0]), 32'd1);
    checkOutput("t1_m_we", 32'(m_we[0]), 32'd1);
    checkOutput("t1_m_addr", 32'(m_addr[0]), 32'h0010);
    checkOutput("t1_m_wdata", 32'(m_wdata[0]), 32'hBEEF);
    checkOutput("t1_ack_early", 32'(p_ack[0]), 32'd0);
    checkOutput("t1_stall_pending", 32'(p_stall[0]), 32'd1);
    @(negedge clk);
    checkOutput("t1_p_ack", 32'(p_ack[0]), 32'd1);
    checkOutput("t1_m_en_pulse", 32'(m_en[0]), 32'd0);
    checkOutput("t1_stall_at_ack", 32'(p_stall[0]), 32'd0);
    p_req[0] = 1'b0;
    @(negedge clk);
    checkOutput("t1_ack_one_cycle", 32'(p_ack[0]), 32'd0);
    checkOutput("t1_idle_busy", 32'(busy[0]), 32'd0);

    $display("[TB] t2: P read, LAT=3");
    applyStimulus(1, 1'b0, 1'b1, 16'h0020, 16'h1234, 2, 16'h0, "t2_wr");
    applyStimulus(1, 1'b0, 1'b0, 16'h0020, 16'h0, 5, 16'h1234, "t2_rd");

    $display("[TB] t3: simultaneous P and D reads");
    applyReset();
    applyStimulus(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA, 2, 16'h0, "t3_pwr");
    applyStimulus(0, 1'b1, 1'b1, 16'h0031, 16'h5555, 2, 16'h0, "t3_dwr");
    applyReset();
    @(negedge clk);
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 16'h0030;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0031;
    pn = 0; dn = 0;
    for (int n = 1; n <= 20 && dn == 0; n++) begin
      @(negedge clk);
      if (n == 2) checkOutput("t3_stall_pending", 32'(p_stall[0]), 32'd1);
      if (p_ack[0]) begin
        if (pn == 0) pn = n;
        checkOutput("t3_p_rdata", 32'(p_rdata[0]), 32'hAAAA);
        checkOutput("t3_stall_at_ack", 32'(p_stall[0]), 32'd0);
        p_req[0] = 1'b0;
      end
      if (d_ack[0]) begin
        dn = n;
        checkOutput("t3_d_rdata", 32'(d_rdata[0]), 32'h5555);
        d_req[0] = 1'b0;
      end
    end
    p_req[0] = 1'b0; d_req[0] = 1'b0;
    checkOutput("t3_p_ack_cycle", 32'(pn), 32'd3);
    checkOutput("t3_d_ack_cycle", 32'(dn), 32'd7);
    checkOutput("t3_p_rdata_hold", 32'(p_rdata[0]), 32'hAAAA);

    $display("[TB] t4: both ports requesting continuously");
    applyReset();
    @(negedge clk);
    p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 16'h0060; p_wdata[0] = 16'h0001;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0070; d_wdata[0] = 16'h0002;
    idx = 0;
    for (int i = 0; i < 4; i++) order[i] = 9;
    for (int n = 0; n < 40 && idx < 4; n++) begin
      @(negedge clk);
      if (p_ack[0] && idx < 4) begin order[idx] = 0; idx++; p_addr[0] = p_addr[0] + 16'd1; end
      if (d_ack[0] && idx < 4) begin order[idx] = 1; idx++; d_addr[0] = d_addr[0] + 16'd1; end
    end
    p_req[0] = 1'b0; d_req[0] = 1'b0;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t4_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));

    $display("[TB] t5: reset during D read wait");
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0020;
    @(negedge clk);
    checkOutput("t5_m_en", 32'(m_en[1]), 32'd1);
    @(negedge clk);
    checkOutput("t5_busy_wait", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    p_req[1] = 1'b1;
    #1;
    checkOutput("t5_rst_d_ack", 32'(d_ack[1]), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy[1]), 32'd0);
    checkOutput("t5_rst_m_addr", 32'(m_addr[1]), 32'd0);
    checkOutput("t5_rst_m_en", 32'(m_en[1]), 32'd0);
    checkOutput("t5_rst_d_rdata", 32'(d_rdata[1]), 32'd0);
    checkOutput("t5_rst_stall", 32'(p_stall[1]), 32'd1);
    p_req[1] = 1'b0; d_req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    d_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack[1]) d_seen = 1;
    end
    checkOutput("t5_no_d_ack", 32'(d_seen), 32'd0);
    applyStimulus(1, 1'b0, 1'b1, 16'h0050, 16'hC0DE, 2, 16'h0, "t5_pwr");
    checkOutput("t5_mem_written", 32'(g_inst[1].mem[8'h50]), 32'hC0DE);

    $display("[TB] t6: D write to top address then P read, LAT=1");
    applyStimulus(0, 1'b1, 1'b1, 16'hFFFF, 16'h00FF, 2, 16'h0, "t6_dwr");
    applyStimulus(0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 3, 16'h00FF, "t6_prd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
